// File: rtl/alu_pkg.sv
// Shared constants for the bit-serial ALU: opcodes, FSM encoding, slice
// function select and default geometry.
package alu_pkg;

  localparam int unsigned ALU_WIDTH_DEF = 32;
  localparam int unsigned ALU_SLICE_DEF = 1;

  // Opcodes are plain constants because ctrl_i may carry undefined codes.
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Per-slice operation; NOR is AND with both operands inverted.
  typedef enum logic [1:0] {
    FN_AND = 2'd0,
    FN_OR  = 2'd1,
    FN_ADD = 2'd2
  } slice_fn_e;

  // Captured operation.
  typedef struct packed {
    logic [3:0] op;
  } alu_req_t;

  // SUB and SLT both run A + ~B + 1.
  function automatic logic op_is_sub(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// SLICE-bit combinational AND/OR/add slice with operand inverts and a
// ripple carry chain. msb_cin_o is the carry into the slice's top bit,
// used for signed overflow on the final slice.
module alu_slice
  import alu_pkg::*;
#(
  parameter int unsigned SLICE = ALU_SLICE_DEF
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             a_inv_i,
  input  logic             b_inv_i,
  input  logic             cin_i,
  input  slice_fn_e        fn_i,
  output logic [SLICE-1:0] res_o,
  output logic             cout_o,
  output logic             msb_cin_o
);

  logic [SLICE-1:0] aa, bb;
  logic [SLICE:0]   c;

  assign aa   = a_inv_i ? ~a_i : a_i;
  assign bb   = b_inv_i ? ~b_i : b_i;
  assign c[0] = cin_i;

  for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
    assign c[gi+1] = (aa[gi] & bb[gi]) | (c[gi] & (aa[gi] ^ bb[gi]));
  end

  assign cout_o    = c[SLICE];
  assign msb_cin_o = c[SLICE-1];

  // Select the slice function.
  always_comb begin
    res_o = '0;
    case (fn_i)
      FN_AND:  res_o = aa & bb;
      FN_OR:   res_o = aa | bb;
      FN_ADD:  res_o = aa ^ bb ^ c[SLICE-1:0];
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU: accepts an operation in IDLE, processes SLICE bits per
// clock in RUN (LSB slice first, carry held in a register between slices),
// then presents result and flags in DONE until the consumer takes them.
module alu_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH_DEF,
  parameter int unsigned SLICE = ALU_SLICE_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  alu_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  alu_req_t         req_q;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, cout_q, ovf_q;

  // Slice controls decoded from the captured opcode.
  logic      a_inv, b_inv;
  slice_fn_e fn;
  logic [SLICE-1:0] sl_res;
  logic      sl_cout, sl_msb_cin;

  always_comb begin
    a_inv = 1'b0;
    b_inv = 1'b0;
    fn    = FN_AND;
    case (req_q.op)
      OP_AND:         fn = FN_AND;
      OP_OR:          fn = FN_OR;
      OP_ADD:         fn = FN_ADD;
      OP_SUB, OP_SLT: begin fn = FN_ADD; b_inv = 1'b1; end
      OP_NOR:         begin fn = FN_AND; a_inv = 1'b1; b_inv = 1'b1; end
      default:        fn = FN_AND;
    endcase
  end

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a_i      (a_q[SLICE-1:0]),
    .b_i      (b_q[SLICE-1:0]),
    .a_inv_i  (a_inv),
    .b_inv_i  (b_inv),
    .cin_i    (carry_q),
    .fn_i     (fn),
    .res_o    (sl_res),
    .cout_o   (sl_cout),
    .msb_cin_o(sl_msb_cin)
  );

  // Accumulate slices from the top so slice 0 lands at bit 0 after N
  // shifts; on the final RUN edge derive result and flags.
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] fin_res;
  logic             fin_cout, fin_ovf, fin_zero, fin_known, sl_ovf;
  logic             last;

  always_comb begin
    acc_d     = (acc_q >> SLICE) | (WIDTH'(sl_res) << (WIDTH - SLICE));
    sl_ovf    = sl_msb_cin ^ sl_cout;
    last      = (cnt_q == CW'(N - 1));
    fin_res   = acc_d;
    fin_cout  = 1'b0;
    fin_ovf   = 1'b0;
    fin_known = 1'b1;
    case (req_q.op)
      OP_AND, OP_OR, OP_NOR: ;
      OP_ADD, OP_SUB: begin
        fin_cout = sl_cout;
        fin_ovf  = sl_ovf;
      end
      OP_SLT: begin
        fin_res  = {{(WIDTH-1){1'b0}}, sl_res[SLICE-1] ^ sl_ovf};
        fin_cout = sl_cout;
      end
      default: begin
        fin_res   = '0;
        fin_known = 1'b0;
      end
    endcase
    // Undefined opcodes report every flag, including zero, as 0.
    fin_zero = fin_known && (fin_res == '0);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      req_q       <= '{op: OP_AND};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i && in_ready_q) begin
            a_q        <= src1_i;
            b_q        <= src2_i;
            req_q      <= '{op: ctrl_i};
            cnt_q      <= '0;
            carry_q    <= op_is_sub(ctrl_i);
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> SLICE;
          b_q     <= b_q >> SLICE;
          acc_q   <= acc_d;
          carry_q <= sl_cout;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            result_q    <= fin_res;
            zero_q      <= fin_zero;
            cout_q      <= fin_cout;
            ovf_q       <= fin_ovf;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign cout_o      = cout_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial: a 32-bit/1-bit-slice instance driven from a
// vector table, and an 8-bit/4-bit-slice instance for stall and carry cases.
module tb_alu_serial;
  import alu_pkg::*;

  logic clk, rst;
  int   cyc;
  int   total, bad;

  // 32-bit instance
  logic        v32, rdy32, ov32, or32, z32, c32, f32;
  logic [31:0] a32, b32, res32;
  logic [3:0]  op32;

  // 8-bit instance
  logic        v8, rdy8, ov8, or8, z8, c8, f8;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  op8;

  alu_serial #(.WIDTH(32), .SLICE(1)) u32 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v32), .in_ready_o(rdy32),
    .src1_i(a32), .src2_i(b32), .ctrl_i(op32), .out_valid_o(ov32),
    .out_ready_i(or32), .result_o(res32), .zero_o(z32), .cout_o(c32),
    .overflow_o(f32)
  );

  alu_serial #(.WIDTH(8), .SLICE(4)) u8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v8), .in_ready_o(rdy8),
    .src1_i(a8), .src2_i(b8), .ctrl_i(op8), .out_valid_o(ov8),
    .out_ready_i(or8), .result_o(res8), .zero_o(z8), .cout_o(c8),
    .overflow_o(f8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        z, c, v, chk_z;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Wait for IDLE, present one op, return the accept cycle; scramble inputs
  // afterwards so any late sampling shows up in the result.
  task automatic start32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int acc);
    int g = 0;
    @(negedge clk);
    while (!rdy32 && g < 200) begin @(negedge clk); g++; end
    op32 = op; a32 = a; b32 = b; v32 = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    v32 = 1'b0; a32 = ~a; b32 = ~b; op32 = OP_NOR;
  endtask

  task automatic wait32(output int lat);
    lat = 0;
    while (!ov32 && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic start8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int g = 0;
    @(negedge clk);
    while (!rdy8 && g < 200) begin @(negedge clk); g++; end
    op8 = op; a8 = a; b8 = b; v8 = 1'b1;
    @(posedge clk);
    #1;
    v8 = 1'b0; a8 = ~a; b8 = ~b; op8 = OP_AND;
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    while (!ov8 && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  initial begin
    int lat, acc, prev;
    total = 0; bad = 0; cyc = 0;
    //          op      a             b             res           z     c     v     chk_z
    tbl[0]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{OP_SLT, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{OP_SLT, 32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{OP_AND, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{OP_OR,  32'hF0F00000, 32'h0000000F, 32'hF0F0000F, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{OP_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{OP_SUB, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{4'b1111, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{OP_ADD, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    v32 = 1'b0; a32 = '0; b32 = '0; op32 = '0; or32 = 1'b1;
    v8  = 1'b0; a8  = '0; b8  = '0; op8  = '0; or8  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst in_ready", rdy32, 1);
    chk("rst out_valid", ov32, 0);
    chk("rst result", res32, 0);
    chk("rst zero", z32, 1);
    chk("rst cout", c32, 0);
    chk("rst ovf", f32, 0);

    // Table with out_ready held high: ops run back to back.
    prev = 0;
    for (int i = 0; i < 12; i++) begin
      start32(tbl[i].op, tbl[i].a, tbl[i].b, acc);
      wait32(lat);
      chk($sformatf("v%0d latency", i), lat, 32);
      if (i > 0) chk($sformatf("v%0d accept gap", i), acc - prev, 34);
      prev = acc;
      chk($sformatf("v%0d result", i), res32, tbl[i].res);
      chk($sformatf("v%0d cout", i), c32, tbl[i].c);
      chk($sformatf("v%0d ovf", i), f32, tbl[i].v);
      if (tbl[i].chk_z) chk($sformatf("v%0d zero", i), z32, tbl[i].z);
    end

    // Reset lands on the 10th RUN edge; nothing is delivered.
    start32(OP_ADD, 32'h0000FFFF, 32'h00000001, acc);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrun rst in_ready", rdy32, 1);
    chk("midrun rst out_valid", ov32, 0);
    chk("midrun rst result", res32, 0);
    chk("midrun rst zero", z32, 1);
    chk("midrun rst cout", c32, 0);
    chk("midrun rst ovf", f32, 0);
    start32(OP_ADD, 32'd3, 32'd4, acc);
    wait32(lat);
    chk("after rst latency", lat, 32);
    chk("after rst result", res32, 32'd7);

    // 8-bit, 4-bit slices: NOR then hold in DONE with in_valid pulses.
    start8(OP_NOR, 8'hF0, 8'h0C);
    wait8(lat);
    chk("w8 nor latency", lat, 2);
    chk("w8 nor result", res8, 8'h03);
    chk("w8 nor flags", {z8, c8, f8}, 3'b000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      v8 = 1'b1; a8 = 8'h55 + 8'(k); b8 = 8'h0F; op8 = OP_ADD;
      @(posedge clk);
      #1;
      chk($sformatf("w8 stall%0d valid/ready", k), {ov8, rdy8}, 2'b10);
      chk($sformatf("w8 stall%0d result", k), res8, 8'h03);
      chk($sformatf("w8 stall%0d flags", k), {z8, c8, f8}, 3'b000);
    end
    @(negedge clk);
    v8 = 1'b0; or8 = 1'b1;
    @(posedge clk);
    #1;
    chk("w8 release valid/ready", {ov8, rdy8}, 2'b01);
    chk("w8 idle holds result", res8, 8'h03);

    start8(OP_ADD, 8'hFF, 8'h01);
    wait8(lat);
    chk("w8 add carry latency", lat, 2);
    chk("w8 add carry result", res8, 8'h00);
    chk("w8 add carry flags", {z8, c8, f8}, 3'b110);

    start8(OP_SLT, 8'h80, 8'h01);
    wait8(lat);
    chk("w8 slt result", res8, 8'h01);
    chk("w8 slt flags", {z8, c8, f8}, 3'b010);

    start8(OP_ADD, 8'h7F, 8'h01);
    wait8(lat);
    chk("w8 add ovf result", res8, 8'h80);
    chk("w8 add ovf flags", {z8, c8, f8}, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_serial.md
ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are multiples of SLICE, at least 2.
REQ-002 SHALL have parameter SLICE, default 1, bits processed per clock cycle; WIDTH % SLICE == 0.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid_i  input  1  operands and opcode valid.
REQ-006 SHALL have port in_ready_o  output  1  block can accept an operation.
REQ-007 SHALL have port src1_i  input  WIDTH  operand A.
REQ-008 SHALL have port src2_i  input  WIDTH  operand B.
REQ-009 SHALL have port ctrl_i  input  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-010 SHALL have port out_valid_o  output  1  result and flags valid.
REQ-011 SHALL have port out_ready_i  input  1  consumer takes the result.
REQ-012 SHALL have port result_o  output  WIDTH  result.
REQ-013 SHALL have port zero_o  output  1  result_o == 0.
REQ-014 SHALL have port cout_o  output  1  carry out of MSB (ADD/SUB/SLT), else 0.
REQ-015 SHALL have port overflow_o  output  1  two's-complement overflow (ADD/SUB), else 0.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; in_ready_o = 1 only in IDLE; out_valid_o = 1 only in DONE.
REQ-017 SHALL, on an edge with in_valid_i & in_ready_o, capture src1_i, src2_i, ctrl_i, clear the slice counter, set carry = 1 for SUB/SLT and 0 otherwise, and enter RUN.
REQ-018 SHALL, in RUN, process slice k (bits k*SLICE..k*SLICE+SLICE-1) on the k-th edge, with A_invert = 1 for NOR, B_invert = 1 for SUB/SLT/NOR, and the carry rippling between successive slices through a carry register.
REQ-019 SHALL leave RUN for DONE on the N-th RUN edge (N = WIDTH/SLICE), so out_valid_o rises exactly N edges after the accepting edge.
REQ-020 SHALL compute overflow as (carry into MSB) XOR (carry out of MSB), using only the final slice.
REQ-021 SHALL produce result_o = {WIDTH-1 zeros, sign XOR overflow} for SLT, where sign is the MSB of A-B; cout_o is the subtract carry.
REQ-022 SHALL produce result_o = 0 and all flags 0 for undefined ctrl_i codes, with unchanged latency.
REQ-023 SHALL hold result_o and all flags stable in DONE until out_ready_i = 1, then return to IDLE on that edge.
REQ-024 SHALL allow a new operation to be accepted no earlier than the edge after the DONE->IDLE edge (throughput one op per N+2 cycles).
REQ-025 SHALL ignore in_valid_i, src1_i, src2_i and ctrl_i changes outside IDLE.
REQ-026 SHALL keep result_o and flags at their last values in IDLE and RUN (no intermediate exposure is required to be meaningful while out_valid_o = 0).

Reset
REQ-027 SHALL, on an edge with rst_i = 1, enter IDLE and clear the counter, carry register, result_o, cout_o and overflow_o to 0, set zero_o to 1, set in_ready_o to 1 and out_valid_o to 0; rst_i takes priority over all other inputs.
REQ-028 SHALL abandon any operation in RUN or DONE on reset, with no result delivered.

Structure
REQ-029 SHALL place the opcode constants, the FSM state encoding and the default WIDTH/SLICE values in shared package alu_pkg.
REQ-030 SHALL instantiate one sub-module, alu_slice: a SLICE-bit combinational AND/OR/add slice with A_invert, B_invert, cin and cout, plus MSB carry-in for overflow.

Verification
REQ-031 SHALL cover: WIDTH=32, SLICE=1, ADD 0x7FFFFFFF+1 -> out_valid_o 32 edges after accept, result 0x80000000, overflow_o=1, cout_o=0, zero_o=0.
REQ-032 SHALL cover: SUB 5-5 -> result 0, zero_o=1, cout_o=1, overflow_o=0.
REQ-033 SHALL cover: SLT 0x80000000 vs 1 -> result 1, and SLT 1 vs 0x80000000 -> result 0.
REQ-034 SHALL cover: WIDTH=8, SLICE=4, NOR 0xF0,0x0C -> result 0x03 after 2 RUN edges; with out_ready_i held 0 for 5 cycles, outputs stay stable and in_valid_i pulses are ignored.
REQ-035 SHALL cover: rst_i asserted on the 10th RUN edge -> next cycle in_ready_o=1, out_valid_o=0, result_o=0, zero_o=1, cout_o=0, overflow_o=0; a following ADD 3+4 returns 7.
REQ-036 SHALL cover: back-to-back ops with out_ready_i tied 1 -> each accepted exactly N+2 cycles apart.
